load_store_unit: RTL and testbench

- Memory-side counterpart of the control unit's memory outputs (memory_mask, memory_sign_extension, memory_we).
- Accepts one byte/halfword/word access from the core and converts it into word-aligned, byte-enabled transactions on a valid/ready data-memory bus.
- Returns load data right-aligned and zero- or sign-extended.
- Misaligned accesses that cross a word boundary are split into two sequential word transactions.

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Purpose: turns one byte/half/word core access into word-aligned, byte-enabled memory transactions.
// Latency: aligned access responds 3 cycles after the handshake; a word-crossing access adds 2.
// Backpressure: mem_valid and its payload hold until mem_ready; req_ready is low while busy.
//
// Ports:
//   clk, rst                      clock and async active-high reset
//   req_valid/req_ready/req_*     core-side access (addr, we, mask, sign_ext, wdata)
//   resp_valid, resp_rdata        one-cycle completion pulse with aligned load data (0 for stores)
//   mem_valid/mem_ready/mem_*     word-aligned request bus with byte enables
//   mem_rvalid, mem_rdata         read data / write ack, one pulse per accepted request

package lsu_pkg;
  typedef enum logic [1:0] {
    MASK_BYTE = 2'd0,
    MASK_HALF = 2'd1,
    MASK_WORD = 2'd2
  } memory_mask_t;
endpackage

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  memory_mask_t          req_mask,
  input  logic                  req_sign_ext,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_WAIT0  = 3'd2,
    S_ISSUE1 = 3'd3,
    S_WAIT1  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  memory_mask_t          mask_q;
  logic                  sext_q;
  logic [31:0]           wdata_q;
  logic [31:0]           lo_q, hi_q;
  logic [31:0]           rdata_q;

  logic [1:0]            off;
  logic [2:0]            size;
  logic [3:0]            lane_mask;
  logic [3:0]            end_pos;
  logic                  split;
  logic [7:0]            be_wide;
  logic [63:0]           wdata_wide;
  logic [ADDR_WIDTH-1:0] word_addr, next_addr;
  logic [31:0]           lo_word, hi_word, raw, load_val;
  logic                  finishing;

  assign off = addr_q[1:0];

  always_comb begin
    size      = 3'd4;
    lane_mask = 4'b1111;
    case (mask_q)
      MASK_BYTE: begin size = 3'd1; lane_mask = 4'b0001; end
      MASK_HALF: begin size = 3'd2; lane_mask = 4'b0011; end
      default:   begin size = 3'd4; lane_mask = 4'b1111; end
    endcase
  end

  assign end_pos = {2'b00, off} + {1'b0, size};
  assign split   = end_pos > 4'd4;

  // Lanes and data for both beats in one shifted vector: the low word is the
  // first beat, the high word holds whatever spilled past lane 3.
  assign be_wide    = {4'b0000, lane_mask} << off;
  assign wdata_wide = {32'b0, wdata_q} << {off, 3'b000};

  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign next_addr = word_addr + ADDR_WIDTH'(4);

  // Bypass the arriving word so the response register loads in the same
  // cycle the last beat returns.
  assign lo_word = (state == S_WAIT0) ? mem_rdata : lo_q;
  assign hi_word = (state == S_WAIT1) ? mem_rdata : hi_q;
  assign raw     = 32'({hi_word, lo_word} >> {off, 3'b000});

  always_comb begin
    load_val = raw;
    case (mask_q)
      MASK_BYTE: load_val = {{24{sext_q & raw[7]}}, raw[7:0]};
      MASK_HALF: load_val = {{16{sext_q & raw[15]}}, raw[15:0]};
      default:   load_val = raw;
    endcase
    if (we_q) load_val = 32'b0;
  end

  assign finishing = mem_rvalid &&
                     ((state == S_WAIT0 && !split) || state == S_WAIT1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_ISSUE0;
      end
      S_ISSUE0: begin
        mem_valid = 1'b1;
        mem_addr  = word_addr;
        mem_we    = we_q;
        mem_be    = be_wide[3:0];
        mem_wdata = wdata_wide[31:0];
        if (mem_ready) state_nxt = S_WAIT0;
      end
      S_WAIT0: begin
        if (mem_rvalid) state_nxt = split ? S_ISSUE1 : S_DONE;
      end
      S_ISSUE1: begin
        mem_valid = 1'b1;
        mem_addr  = next_addr;
        mem_we    = we_q;
        mem_be    = be_wide[7:4];
        mem_wdata = wdata_wide[63:32];
        if (mem_ready) state_nxt = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign resp_valid = (state == S_DONE);
  assign resp_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      mask_q  <= MASK_BYTE;
      sext_q  <= 1'b0;
      wdata_q <= 32'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        mask_q  <= req_mask;
        sext_q  <= req_sign_ext;
        wdata_q <= req_wdata;
      end
      if (state == S_WAIT0 && mem_rvalid) lo_q <= mem_rdata;
      if (state == S_WAIT1 && mem_rvalid) hi_q <= mem_rdata;
      if (finishing) rdata_q <= load_val;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a hand-driven memory bus, with every
// expected address, lane mask, data word and response written out literally.
// Inputs change and outputs are sampled 1 ns after the rising clock edge.

module tb_load_store_unit;
  import lsu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_we;
  memory_mask_t req_mask;
  logic         req_sign_ext;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_addr;
  logic         mem_we;
  logic [3:0]   mem_be;
  logic [31:0]  mem_wdata;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int hs_cyc = 0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_mask(req_mask), .req_sign_ext(req_sign_ext),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, complete the handshake, then scramble the core
  // inputs so the unit must work from its captured copy.
  task automatic start_req(input string tag, input logic [31:0] addr, input logic we,
                           input memory_mask_t mask, input logic sext, input logic [31:0] wdata);
    req_addr     = addr;
    req_we       = we;
    req_mask     = mask;
    req_sign_ext = sext;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    #1;
    chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd1);
    hs_cyc = cyc;
    step;
    req_valid    = 1'b0;
    req_addr     = 32'h5A5A_5A5B;
    req_we       = ~we;
    req_mask     = (mask == MASK_WORD) ? MASK_BYTE : MASK_WORD;
    req_sign_ext = ~sext;
    req_wdata    = 32'hA5A5_A5A5;
  endtask

  // One issue beat: hold mem_ready low for 'delay' cycles, then accept.
  task automatic issue(input string tag, input logic [31:0] addr, input logic [3:0] be,
                       input logic we, input logic [31:0] wdata, input int delay);
    for (int i = 0; i <= delay; i++) begin
      mem_ready = (i == delay);
      #1;
      chk({tag, ".mem_valid"}, {31'b0, mem_valid}, 32'd1);
      chk({tag, ".mem_addr"},  mem_addr, addr);
      chk({tag, ".mem_be"},    {28'b0, mem_be}, {28'b0, be});
      chk({tag, ".mem_we"},    {31'b0, mem_we}, {31'b0, we});
      chk({tag, ".mem_wdata"}, mem_wdata, wdata);
      chk({tag, ".req_ready"}, {31'b0, req_ready}, 32'd0);
      step;
    end
    mem_ready = 1'b0;
  endtask

  task automatic ret(input string tag, input logic [31:0] rdata);
    chk({tag, ".wait_mem_valid"}, {31'b0, mem_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    step;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hDEAD_0000;
  endtask

  task automatic finish_req(input string tag, input logic [31:0] exp, input int lat);
    chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, ".resp_rdata"}, resp_rdata, exp);
    chk({tag, ".latency"}, cyc - hs_cyc, lat);
    step;
    chk({tag, ".resp_pulse"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, ".req_ready_back"}, {31'b0, req_ready}, 32'd1);
    chk({tag, ".rdata_hold"}, resp_rdata, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"},  {31'b0, req_ready}, 32'd1);
    chk({tag, ".resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, ".mem_valid"},  {31'b0, mem_valid}, 32'd0);
    chk({tag, ".mem_we"},     {31'b0, mem_we}, 32'd0);
    chk({tag, ".mem_be"},     {28'b0, mem_be}, 32'd0);
    chk({tag, ".mem_addr"},   mem_addr, 32'd0);
    chk({tag, ".mem_wdata"},  mem_wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_mask = MASK_BYTE;
    req_sign_ext = 1'b0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step;
    step;
    chk_reset_outputs("reset");
    rst = 1'b0;
    step;

    // Aligned word load
    start_req("wload", 32'h0000_0100, 1'b0, MASK_WORD, 1'b0, 32'h0);
    issue("wload", 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 0);
    ret("wload", 32'hDEAD_BEEF);
    finish_req("wload", 32'hDEAD_BEEF, 3);

    // Byte loads from lane 3, signed and unsigned
    start_req("bload_s", 32'h0000_0103, 1'b0, MASK_BYTE, 1'b1, 32'h0);
    issue("bload_s", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 0);
    ret("bload_s", 32'h80FF_1234);
    finish_req("bload_s", 32'hFFFF_FF80, 3);

    start_req("bload_u", 32'h0000_0103, 1'b0, MASK_BYTE, 1'b0, 32'h0);
    issue("bload_u", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 0);
    ret("bload_u", 32'h80FF_1234);
    finish_req("bload_u", 32'h0000_0080, 3);

    // Halfword store at offset 2
    start_req("hstore", 32'h0000_0202, 1'b1, MASK_HALF, 1'b0, 32'h0000_ABCD);
    issue("hstore", 32'h0000_0200, 4'b1100, 1'b1, 32'hABCD_0000, 0);
    ret("hstore", 32'h1234_5678);
    finish_req("hstore", 32'h0, 3);

    // Split word load across 0x0FC / 0x100
    start_req("wsplit", 32'h0000_00FE, 1'b0, MASK_WORD, 1'b0, 32'h0);
    issue("wsplit.b0", 32'h0000_00FC, 4'b1100, 1'b0, 32'h0, 0);
    ret("wsplit.b0", 32'h1122_3344);
    issue("wsplit.b1", 32'h0000_0100, 4'b0011, 1'b0, 32'h0, 0);
    ret("wsplit.b1", 32'h5566_7788);
    finish_req("wsplit", 32'h7788_1122, 5);

    // Backpressure: ready low for 5 cycles in ISSUE0
    start_req("bp", 32'h0000_0300, 1'b1, MASK_WORD, 1'b0, 32'hCAFE_F00D);
    issue("bp", 32'h0000_0300, 4'b1111, 1'b1, 32'hCAFE_F00D, 5);
    ret("bp", 32'h0);
    finish_req("bp", 32'h0, 8);

    // Signed halfword at offset 3 splits one byte into the next word
    start_req("hsplit", 32'h0000_0007, 1'b0, MASK_HALF, 1'b1, 32'h0);
    issue("hsplit.b0", 32'h0000_0004, 4'b1000, 1'b0, 32'h0, 0);
    ret("hsplit.b0", 32'hAB00_0000);
    issue("hsplit.b1", 32'h0000_0008, 4'b0001, 1'b0, 32'h0, 0);
    ret("hsplit.b1", 32'h0000_00CD);
    finish_req("hsplit", 32'hFFFF_CDAB, 5);

    // Split word store at offset 1
    start_req("ssplit", 32'h0000_0011, 1'b1, MASK_WORD, 1'b0, 32'hAABB_CCDD);
    issue("ssplit.b0", 32'h0000_0010, 4'b1110, 1'b1, 32'hBBCC_DD00, 0);
    ret("ssplit.b0", 32'h0);
    issue("ssplit.b1", 32'h0000_0014, 4'b0001, 1'b1, 32'h0000_00AA, 0);
    ret("ssplit.b1", 32'h0);
    finish_req("ssplit", 32'h0, 5);

    // Second beat address wraps to zero
    start_req("wrap", 32'hFFFF_FFFE, 1'b0, MASK_WORD, 1'b0, 32'h0);
    issue("wrap.b0", 32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0, 0);
    ret("wrap.b0", 32'h0102_0304);
    issue("wrap.b1", 32'h0000_0000, 4'b0011, 1'b0, 32'h0, 1);
    ret("wrap.b1", 32'h0506_0708);
    finish_req("wrap", 32'h0708_0102, 6);

    // Reset while waiting for read data, then a stray rvalid
    start_req("rstw", 32'h0000_0400, 1'b0, MASK_WORD, 1'b0, 32'h0);
    issue("rstw", 32'h0000_0400, 4'b1111, 1'b0, 32'h0, 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rstw.async");
    step;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    step;
    mem_rvalid = 1'b0;
    chk("rstw.stray_resp0", {31'b0, resp_valid}, 32'd0);
    chk("rstw.stray_ready", {31'b0, req_ready}, 32'd1);
    step;
    chk("rstw.stray_resp1", {31'b0, resp_valid}, 32'd0);

    start_req("after", 32'h0000_0401, 1'b0, MASK_BYTE, 1'b0, 32'h0);
    issue("after", 32'h0000_0400, 4'b0010, 1'b0, 32'h0, 0);
    ret("after", 32'h0000_A500);
    finish_req("after", 32'h0000_00A5, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
